tl_timebase: RTL and testbench

//   First synchronous stage after the clock/reset source. Consumes clk and the raw asynchronous rst_n
//   and produces three things: a synchronised reset, a 1-second tick from a prescaler, and a

---
 rtl/tl_timebase_if.sv | 33 +++
 rtl/tl_timebase.sv | 158 +++++++++++++++
 tb/tb_tl_timebase.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tl_timebase_if.sv
// Bundle of control inputs and status outputs of the traffic-light timebase.
// The clock, raw reset and synchronised reset stay as plain ports on the module.
//
// Request semantics (no valid/ready back-pressure): start and abort are
// single-cycle requests that are always taken on the rising edge where they
// are high. abort wins over start on the same edge. duration is only looked at
// on an edge that accepts start. busy/done/remaining/dbg_state are registered;
// tick_sec is combinational from en and the prescaler count.
interface tl_timebase_if #(
  parameter int unsigned TIMER_W = 8
) ();
  logic               en;
  logic               start;
  logic               abort;
  logic [TIMER_W-1:0] duration;
  logic               tick_sec;
  logic               busy;
  logic               done;
  logic [TIMER_W-1:0] remaining;
  logic [1:0]         dbg_state;

  // Controller side: drives requests, observes status.
  modport master (
    output en, start, abort, duration,
    input  tick_sec, busy, done, remaining, dbg_state
  );

  // Timebase side: receives requests, drives status.
  modport slave (
    input  en, start, abort, duration,
    output tick_sec, busy, done, remaining, dbg_state
  );
endinterface

// File: rtl/tl_timebase.sv
// Traffic-light timebase: reset synchroniser, 1-second prescaler and a
// start/abort seconds countdown used to time the light phases.
module tl_timebase #(
  parameter int unsigned CYCLES_PER_SEC  = 50_000_000,
  parameter int unsigned RST_SYNC_STAGES = 2,
  parameter int unsigned TIMER_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          rst_sync_n,
  tl_timebase_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CYCLES_PER_SEC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_SEC - 1);

  // Timer FSM encoding; also exported on dbg_state.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [RST_SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 state_q, state_d;
  logic [TIMER_W-1:0]         rem_q, rem_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       start_acc;
  logic                       tick;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: clears immediately with rst_n, releases after
  // RST_SYNC_STAGES rising edges. Its output is the async reset for all other
  // flops, so a raw reset pulse reaches them without waiting for a clock.
  // ---------------------------------------------------------------------------

  // Shift ones in behind the released raw reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[RST_SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------

  // abort has priority, so a start that arrives with abort is not taken.
  assign start_acc = bus.start & ~bus.abort;

  // Tick is gated by en so a frozen prescaler cannot emit a tick.
  assign tick = bus.en & (cnt_q == CNT_MAX);

  // Count enabled cycles; an accepted start restarts the second so the first
  // second of a new interval is full length.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = '0;
    end else if (bus.en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Countdown FSM
  // ---------------------------------------------------------------------------

  // Next-state and next-remaining. remaining is always 0 outside RUN, and in
  // RUN it is >=1, so the decrement can never wrap.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE lasts one cycle; abort is a no-op here.
        state_d = ST_IDLE;
        if (start_acc) begin
          if (bus.duration != '0) begin
            state_d = ST_RUN;
            rem_d   = bus.duration;
          end else begin
            state_d = ST_DONE;
            rem_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          // Abort beats both a restart and an expiring tick; no done pulse.
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (start_acc) begin
          // Restart: reload (prescaler is cleared alongside).
          if (bus.duration != '0) begin
            state_d = ST_RUN;
            rem_d   = bus.duration;
          end else begin
            state_d = ST_DONE;
            rem_d   = '0;
          end
        end else if (tick) begin
          if (rem_q == TIMER_W'(1)) begin
            state_d = ST_DONE;
            rem_d   = '0;
          end else begin
            rem_d   = rem_q - TIMER_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Status outputs are registered decodes of the next state.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // FSM and registered status outputs.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tick_sec  = tick;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tl_timebase.sv
// Directed bench for tl_timebase with CYCLES_PER_SEC=4, TIMER_W=8.
module tb_tl_timebase;

  localparam int unsigned CPS = 4;
  localparam int unsigned TW  = 8;

  logic clk;
  logic rst_n;
  logic rst_sync_n;

  tl_timebase_if #(.TIMER_W(TW)) bus ();

  tl_timebase #(
    .CYCLES_PER_SEC (CPS),
    .RST_SYNC_STAGES(2),
    .TIMER_W        (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_sync_n(rst_sync_n),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [TW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n rising edges; return 2ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_timer(input logic [TW-1:0] d);
    bus.duration = d;
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
  endtask

  int done_cnt;

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.duration = '0;

    // ---- 1. reset ----
    step(3);
    check("rst_sync_n_in_reset", 32'(rst_sync_n), 0);
    check("tick_in_reset", 32'(bus.tick_sec), 0);
    check("busy_in_reset", 32'(bus.busy), 0);
    check("done_in_reset", 32'(bus.done), 0);
    check("rem_in_reset", 32'(bus.remaining), 0);
    check("state_in_reset", 32'(bus.dbg_state), 0);
    rst_n = 1'b1;
    step(1);
    check("sync_edge1", 32'(rst_sync_n), 0);
    step(1);
    check("sync_edge2", 32'(rst_sync_n), 1);

    // asynchronous assertion between edges
    #1 rst_n = 1'b0;
    #1 check("sync_async_assert", 32'(rst_sync_n), 0);
    #1 rst_n = 1'b1;
    step(1);
    check("sync_rerelease_edge1", 32'(rst_sync_n), 0);
    step(1);
    check("sync_rerelease_edge2", 32'(rst_sync_n), 1);

    // ---- 2. free run ----
    bus.en = 1'b1;
    #1 check("tick_first_cycle", 32'(bus.tick_sec), 0);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check($sformatf("tick_run_%0d", i), 32'(bus.tick_sec), ((i % 4) == 3) ? 1 : 0);
    end
    step(3);
    check("tick_before_freeze", 32'(bus.tick_sec), 1);
    bus.en = 1'b0;
    #1 check("tick_forced_low", 32'(bus.tick_sec), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("tick_frozen_%0d", i), 32'(bus.tick_sec), 0);
    end
    bus.en = 1'b1;
    #1 check("tick_resume", 32'(bus.tick_sec), 1);
    step(1);
    check("tick_after_resume", 32'(bus.tick_sec), 0);

    // ---- 3. duration=3 ----
    start_timer(8'd3);
    check("d3_busy_e0", 32'(bus.busy), 1);
    check("d3_rem_e0", 32'(bus.remaining), 3);
    check("d3_state_e0", 32'(bus.dbg_state), 1);
    for (int c = 1; c <= 13; c++)
      exp_q.push_back((c < 4) ? 8'd3 : (c < 8) ? 8'd2 : (c < 12) ? 8'd1 : 8'd0);
    for (int c = 1; c <= 13; c++) begin
      step(1);
      check($sformatf("d3_rem_%0d", c), 32'(bus.remaining), 32'(exp_q.pop_front()));
      check($sformatf("d3_busy_%0d", c), 32'(bus.busy), (c < 12) ? 1 : 0);
      check($sformatf("d3_done_%0d", c), 32'(bus.done), (c == 12) ? 1 : 0);
    end

    // ---- 4. duration=0 and duration=255 ----
    start_timer(8'd0);
    check("d0_done", 32'(bus.done), 1);
    check("d0_busy", 32'(bus.busy), 0);
    check("d0_rem", 32'(bus.remaining), 0);
    check("d0_state", 32'(bus.dbg_state), 2);
    step(1);
    check("d0_done_clear", 32'(bus.done), 0);
    check("d0_busy_after", 32'(bus.busy), 0);
    check("d0_state_after", 32'(bus.dbg_state), 0);

    start_timer(8'd255);
    check("d255_rem_e0", 32'(bus.remaining), 255);
    check("d255_busy_e0", 32'(bus.busy), 1);
    for (int c = 1; c <= 1021; c++) begin
      step(1);
      if ((c % 64) == 0)
        check($sformatf("d255_rem_%0d", c), 32'(bus.remaining), 255 - c / 4);
      if (c == 1019) begin
        check("d255_rem_1019", 32'(bus.remaining), 1);
        check("d255_busy_1019", 32'(bus.busy), 1);
        check("d255_done_1019", 32'(bus.done), 0);
      end
      if (c == 1020) begin
        check("d255_done_1020", 32'(bus.done), 1);
        check("d255_rem_1020", 32'(bus.remaining), 0);
        check("d255_busy_1020", 32'(bus.busy), 0);
      end
      if (c == 1021) begin
        check("d255_done_1021", 32'(bus.done), 0);
        check("d255_rem_1021", 32'(bus.remaining), 0);
      end
    end

    // ---- 5. abort, start+abort, restart ----
    start_timer(8'd5);
    step(5);
    check("ab_rem_before", 32'(bus.remaining), 4);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check("ab_state", 32'(bus.dbg_state), 0);
    check("ab_rem", 32'(bus.remaining), 0);
    check("ab_busy", 32'(bus.busy), 0);
    check("ab_done", 32'(bus.done), 0);
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (bus.done) done_cnt++;
    end
    check("ab_no_done", 32'(done_cnt), 0);

    bus.duration = 8'd7;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    step(1);
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    check("sa_state", 32'(bus.dbg_state), 0);
    check("sa_busy", 32'(bus.busy), 0);
    check("sa_rem", 32'(bus.remaining), 0);

    start_timer(8'd5);
    step(8);
    check("rs_rem_c8", 32'(bus.remaining), 3);
    start_timer(8'd2);
    check("rs_rem_c9", 32'(bus.remaining), 2);
    check("rs_busy_c9", 32'(bus.busy), 1);
    step(3);
    check("rs_rem_c12", 32'(bus.remaining), 2);
    step(1);
    check("rs_rem_c13", 32'(bus.remaining), 1);
    step(3);
    check("rs_rem_c16", 32'(bus.remaining), 1);
    check("rs_done_c16", 32'(bus.done), 0);
    step(1);
    check("rs_done_c17", 32'(bus.done), 1);
    check("rs_rem_c17", 32'(bus.remaining), 0);

    // ---- 6. reset mid-run ----
    step(2);
    start_timer(8'd4);
    step(5);
    check("mr_rem_c5", 32'(bus.remaining), 3);
    check("mr_busy_c5", 32'(bus.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_busy_rst", 32'(bus.busy), 0);
    check("mr_rem_rst", 32'(bus.remaining), 0);
    check("mr_done_rst", 32'(bus.done), 0);
    check("mr_sync_rst", 32'(rst_sync_n), 0);
    check("mr_state_rst", 32'(bus.dbg_state), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    check("mr_sync_release", 32'(rst_sync_n), 1);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (bus.done) done_cnt++;
    end
    check("mr_no_done", 32'(done_cnt), 0);
    check("mr_state_after", 32'(bus.dbg_state), 0);
    check("mr_rem_after", 32'(bus.remaining), 0);

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
